clk_gate_ctrl: RTL and testbench
================================

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 SHALL have parameter IDLE_CYCLES, default 8: consecutive idle cycles in RUN before gating, legal range 2..255.
REQ-002 SHALL have parameter WAKE_DLY, default 2: cycles spent in WAKE before returning to RUN, legal range 1..15.
REQ-003 SHALL have port CLK, input, 1 bit: single free-running clock; all state changes on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port BUSY, input, 1 bit: activity indication from the gated domain.
REQ-006 SHALL have port WAKE_REQ, input, 1 bit: external wake request, level, held until WAKE_ACK.
REQ-007 SHALL have port WAKE_ACK, output, 1 bit: one-cycle acknowledge of WAKE_REQ.
REQ-008 SHALL have port GATE_EN, output, 1 bit: registered enable; drives a negative-level latch ahead of the AND2X1 clock gate.
REQ-009 SHALL have port STATE, output, 2 bits: current FSM state, encoded RUN=0, DRAIN=1, GATED=2, WAKE=3.
REQ-010 SHALL have port GATED_CNT, output, 16 bits: statistics counter (see Configuration).

Function
REQ-011 SHALL change all outputs only on the rising edge of CLK, with no combinational path from any input to any output.
REQ-012 In RUN, SHALL increment idle_cnt on each edge where BUSY=0 and clear it on each edge where BUSY=1.
REQ-013 In RUN, SHALL transition to DRAIN on the edge where BUSY=0 and idle_cnt==IDLE_CYCLES-1, i.e. after IDLE_CYCLES consecutive idle edges.
REQ-014 If BUSY=1 coincides with the threshold edge, SHALL stay in RUN and clear idle_cnt (BUSY wins).
REQ-015 In DRAIN (one cycle, GATE_EN=1), SHALL return to RUN with idle_cnt=0 if BUSY=1 or WAKE_REQ=1, else go to GATED.
REQ-016 SHALL drive GATE_EN=0 in GATED and GATE_EN=1 in all other states.
REQ-017 In GATED, SHALL go to WAKE on any edge where BUSY=1 or WAKE_REQ=1.
REQ-018 In WAKE, SHALL count wake_cnt from 0 and go to RUN on the edge where wake_cnt==WAKE_DLY-1; BUSY is ignored in WAKE.
REQ-019 SHALL assert WAKE_ACK for exactly the first RUN cycle after WAKE when WAKE_REQ=1 at the WAKE-to-RUN edge.
REQ-020 SHALL assert WAKE_ACK in the cycle after WAKE_REQ is sampled high while in RUN, provided no ack was already issued for that request.
REQ-021 SHALL NOT re-assert WAKE_ACK until WAKE_REQ has been sampled low for at least one edge after the previous ack.
REQ-022 SHALL make WAKE_REQ in DRAIN abort to RUN and be acknowledged per REQ-020.
REQ-023 SHALL keep idle_cnt and wake_cnt saturating, with no wrap-around under any input sequence.

Reset
REQ-024 While RST=1 at an edge, SHALL set STATE=RUN, GATE_EN=1, WAKE_ACK=0, idle_cnt=0, wake_cnt=0, GATED_CNT=0.
REQ-025 SHALL give RST priority over all other inputs, including when asserted mid-GATED or mid-WAKE; GATE_EN returns to 1 at the first reset edge.
REQ-026 After RST deasserts, SHALL require IDLE_CYCLES fresh idle edges before gating, and SHALL treat any pending ack-suppression as cleared.

Configuration
REQ-027 With macro CGC_STATS_EN defined, SHALL increment GATED_CNT by 1 on each edge spent in GATED, saturating at 16'hFFFF, cleared only by RST.
REQ-028 Without CGC_STATS_EN, SHALL keep the GATED_CNT port present, tied to 16'h0000, with no counter logic synthesized.

Verification
REQ-029 SHALL cover: RST pulse, then BUSY=0 held -> STATE=DRAIN after edge 8, STATE=GATED and GATE_EN=0 after edge 9.
REQ-030 SHALL cover: BUSY=0 for 7 edges, then BUSY=1 on edge 8 -> STATE stays RUN, idle_cnt=0, GATE_EN never 0.
REQ-031 SHALL cover: in GATED, BUSY=1 for one edge -> STATE=WAKE and GATE_EN=1 next cycle, STATE=RUN 2 edges later, WAKE_ACK stays 0.
REQ-032 SHALL cover: in GATED, WAKE_REQ held high -> WAKE_ACK=1 for exactly one cycle in the first RUN cycle; held WAKE_REQ produces no second ack.
REQ-033 SHALL cover: RST asserted during WAKE (wake_cnt=1) -> next cycle STATE=RUN, GATE_EN=1, WAKE_ACK=0, GATED_CNT=0.
REQ-034 SHALL cover, with CGC_STATS_EN defined: 20 edges in GATED -> GATED_CNT=20; without CGC_STATS_EN the same stimulus -> GATED_CNT=0.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// Idle-driven clock-gate controller: RUN -> DRAIN -> GATED -> WAKE -> RUN, with a registered gate enable.
// Optional gated-cycle statistics counter is enabled by defining CGC_STATS_EN.
module clk_gate_ctrl #(
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_DLY    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        BUSY,
  input  logic        WAKE_REQ,
  output logic        WAKE_ACK,
  output logic        GATE_EN,
  output logic [1:0]  STATE,
  output logic [15:0] GATED_CNT
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_GATED = 2'd2;
  localparam logic [1:0] S_WAKE  = 2'd3;

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [3:0] WAKE_LAST = 4'(WAKE_DLY - 1);

  logic [1:0] state, state_nxt;
  logic [7:0] idle_cnt, idle_nxt;
  logic [3:0] wake_cnt, wake_nxt;
  logic       acked;
  logic       wake_done;

  assign wake_done = (state == S_WAKE) && (wake_cnt >= WAKE_LAST);

  // Counters leave their state at the threshold (>=), so they can never wrap.
  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    wake_nxt  = wake_cnt;
    case (state)
      S_RUN: begin
        if (BUSY) begin
          idle_nxt = '0;
        end else if (idle_cnt >= IDLE_LAST) begin
          state_nxt = S_DRAIN;
          idle_nxt  = '0;
        end else begin
          idle_nxt = idle_cnt + 8'd1;
        end
      end
      S_DRAIN: begin
        idle_nxt  = '0;
        state_nxt = (BUSY || WAKE_REQ) ? S_RUN : S_GATED;
      end
      S_GATED: begin
        if (BUSY || WAKE_REQ) begin
          state_nxt = S_WAKE;
          wake_nxt  = '0;
        end
      end
      S_WAKE: begin
        if (wake_done) begin
          state_nxt = S_RUN;
          wake_nxt  = '0;
        end else begin
          wake_nxt = wake_cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = S_RUN;
        idle_nxt  = '0;
        wake_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_RUN;
      idle_cnt <= '0;
      wake_cnt <= '0;
      GATE_EN  <= 1'b1;
      WAKE_ACK <= 1'b0;
      acked    <= 1'b0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_nxt;
      wake_cnt <= wake_nxt;
      GATE_EN  <= (state_nxt != S_GATED);
      WAKE_ACK <= 1'b0;
      // One ack per request level; a low sample re-arms the next ack.
      if (!WAKE_REQ) begin
        acked <= 1'b0;
      end else if (!acked && ((state == S_RUN) || wake_done)) begin
        WAKE_ACK <= 1'b1;
        acked    <= 1'b1;
      end
    end
  end

  assign STATE = state;

`ifdef CGC_STATS_EN
  logic [15:0] gated_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      gated_cnt <= '0;
    end else if ((state == S_GATED) && (gated_cnt != 16'hFFFF)) begin
      gated_cnt <= gated_cnt + 16'd1;
    end
  end

  assign GATED_CNT = gated_cnt;
`else
  assign GATED_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed-vector bench for clk_gate_ctrl; expected outputs queued per cycle and checked by a monitor.
// GATED_CNT expectations follow CGC_STATS_EN.
module tb_clk_gate_ctrl;

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] GATED = 2'd2;
  localparam logic [1:0] WAKE  = 2'd3;

`ifdef CGC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        BUSY = 1'b0;
  logic        WAKE_REQ = 1'b0;
  logic        WAKE_ACK;
  logic        GATE_EN;
  logic [1:0]  STATE;
  logic [15:0] GATED_CNT;

  typedef struct {
    logic [1:0]  st;
    logic        ge;
    logic        ack;
    logic [15:0] cnt;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  clk_gate_ctrl #(.IDLE_CYCLES(8), .WAKE_DLY(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .BUSY      (BUSY),
    .WAKE_REQ  (WAKE_REQ),
    .WAKE_ACK  (WAKE_ACK),
    .GATE_EN   (GATE_EN),
    .STATE     (STATE),
    .GATED_CNT (GATED_CNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] gc(input int n);
    return STATS ? 16'(n) : 16'h0000;
  endfunction

  // One clock: drive inputs mid-cycle, queue the outputs expected after the next rising edge.
  task automatic cyc(input logic rst, input logic busy, input logic req,
                     input logic [1:0] st, input logic ge, input logic ack,
                     input logic [15:0] cnt, input string nm);
    exp_t e;
    @(negedge CLK);
    RST = rst;
    BUSY = busy;
    WAKE_REQ = req;
    e.st = st; e.ge = ge; e.ack = ack; e.cnt = cnt; e.nm = nm;
    exp_q.push_back(e);
  endtask

  always @(posedge CLK) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (STATE !== e.st || GATE_EN !== e.ge || WAKE_ACK !== e.ack || GATED_CNT !== e.cnt) begin
        n_fail++;
        $display("FAIL %s @%0t: got state=%0d gate_en=%0b ack=%0b cnt=%0d, want state=%0d gate_en=%0b ack=%0b cnt=%0d",
                 e.nm, $time, STATE, GATE_EN, WAKE_ACK, GATED_CNT, e.st, e.ge, e.ack, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(1, 0, 0, RUN, 1, 0, 0, "reset0");
    cyc(1, 1, 1, RUN, 1, 0, 0, "reset1");

    for (int i = 0; i < 7; i++) cyc(0, 0, 0, RUN, 1, 0, 0, "idle_count");
    cyc(0, 0, 0, DRAIN, 1, 0, 0, "enter_drain");
    cyc(0, 0, 0, GATED, 0, 0, 0, "enter_gated");

    for (int i = 1; i <= 20; i++) cyc(0, 0, 0, GATED, 0, 0, gc(i), "gated_hold");

    cyc(0, 1, 0, WAKE, 1, 0, gc(21), "busy_wake");
    cyc(0, 0, 0, WAKE, 1, 0, gc(21), "wake_dly");
    cyc(0, 0, 0, RUN,  1, 0, gc(21), "wake_to_run_noack");

    for (int i = 0; i < 7; i++) cyc(0, 0, 0, RUN, 1, 0, gc(21), "idle_pre_busy");
    cyc(0, 1, 0, RUN, 1, 0, gc(21), "busy_at_threshold");
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, RUN, 1, 0, gc(21), "idle_recount");
    cyc(0, 0, 0, DRAIN, 1, 0, gc(21), "drain_after_recount");

    cyc(0, 0, 1, RUN, 1, 0, gc(21), "drain_req_abort");
    cyc(0, 1, 1, RUN, 1, 1, gc(21), "run_req_ack");
    cyc(0, 1, 1, RUN, 1, 0, gc(21), "run_req_held");
    cyc(0, 1, 0, RUN, 1, 0, gc(21), "run_req_drop");

    for (int i = 0; i < 7; i++) cyc(0, 0, 0, RUN, 1, 0, gc(21), "idle_2");
    cyc(0, 0, 0, DRAIN, 1, 0, gc(21), "drain_2");
    cyc(0, 0, 0, GATED, 0, 0, gc(21), "gated_2");
    cyc(0, 0, 1, WAKE, 1, 0, gc(22), "req_wake");
    cyc(0, 0, 1, WAKE, 1, 0, gc(22), "req_wake_dly");
    cyc(0, 0, 1, RUN,  1, 1, gc(22), "wake_run_ack");
    cyc(0, 0, 1, RUN,  1, 0, gc(22), "held_no_reack0");
    cyc(0, 0, 1, RUN,  1, 0, gc(22), "held_no_reack1");
    cyc(0, 1, 0, RUN,  1, 0, gc(22), "req_release");

    for (int i = 0; i < 7; i++) cyc(0, 0, 0, RUN, 1, 0, gc(22), "idle_3");
    cyc(0, 0, 0, DRAIN, 1, 0, gc(22), "drain_3");
    cyc(0, 0, 0, GATED, 0, 0, gc(22), "gated_3");
    cyc(0, 1, 0, WAKE, 1, 0, gc(23), "wake_3");
    cyc(0, 0, 0, WAKE, 1, 0, gc(23), "wake_cnt1");
    cyc(1, 0, 0, RUN,  1, 0, 0, "reset_mid_wake");

    for (int i = 0; i < 7; i++) cyc(0, 0, 0, RUN, 1, 0, 0, "post_reset_idle");
    cyc(0, 0, 0, DRAIN, 1, 0, 0, "post_reset_drain");
    cyc(0, 1, 0, RUN, 1, 0, 0, "drain_busy_abort");
    cyc(0, 1, 1, RUN, 1, 1, 0, "ack_a");
    cyc(0, 1, 1, RUN, 1, 0, 0, "ack_a_held");
    cyc(0, 1, 0, RUN, 1, 0, 0, "ack_rearm");
    cyc(0, 1, 1, RUN, 1, 1, 0, "ack_b");
    cyc(0, 1, 0, RUN, 1, 0, 0, "ack_b_drop");

    for (int i = 0; i < 7; i++) cyc(0, 0, 0, RUN, 1, 0, 0, "idle_4");
    cyc(0, 0, 0, DRAIN, 1, 0, 0, "drain_4");
    cyc(0, 0, 0, GATED, 0, 0, 0, "gated_4");
    cyc(0, 0, 0, GATED, 0, 0, gc(1), "gated_4_hold");
    cyc(1, 0, 0, RUN,  1, 0, 0, "reset_mid_gated");
    cyc(0, 1, 0, RUN,  1, 0, 0, "after_reset_busy");

    repeat (3) @(posedge CLK);
    #2;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_queue: %0d expectations unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
